// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, message-schedule FSM encoding and
// the small-sigma functions used by schedule expansion.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_expand.sv
// Combinational schedule expansion: next word from four taps of the window.
module msg_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] new_word
);

  // Wraps modulo 2^32; carries out of bit 31 are dropped by the width.
  assign new_word = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: serial 16-word load, then W[0..63] one per NEXT,
// with a one-cycle DONE pulse after the last word is taken.
module msg_schedule
  import sha256_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [WORD_W-1:0] DIN,
  input  logic              NEXT,
  output logic [WORD_W-1:0] W,
  output logic [5:0]        T,
  output logic              VALID,
  output logic              DONE
);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] win_reg  [BLOCK_WORDS];
  logic [WORD_W-1:0] win_next [BLOCK_WORDS];
  logic [3:0]        lc_reg, lc_next;
  logic [5:0]        t_reg, t_next;
  logic              shift_en;
  logic [WORD_W-1:0] shift_in;
  logic [WORD_W-1:0] new_word;

  msg_expand u_expand (
    .w0       (win_reg[0]),
    .w1       (win_reg[1]),
    .w9       (win_reg[9]),
    .w14      (win_reg[14]),
    .new_word (new_word)
  );

  always_comb begin
    state_next = state_reg;
    lc_next    = lc_reg;
    t_next     = t_reg;
    shift_en   = 1'b0;
    shift_in   = DIN;
    case (state_reg)
      IDLE: begin
        if (LOAD) begin
          shift_en = 1'b1;
          lc_next  = lc_reg + 4'd1;
          if (lc_reg == 4'(BLOCK_WORDS - 1)) begin
            state_next = RUN;
            lc_next    = 4'd0;
            t_next     = 6'd0;
          end
        end
      end
      RUN: begin
        if (NEXT) begin
          // The last round leaves without shifting; T holds at 63 through FIN.
          if (t_reg == 6'(ROUNDS - 1)) begin
            state_next = FIN;
          end else begin
            shift_en = 1'b1;
            shift_in = new_word;
            t_next   = t_reg + 6'd1;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_win
      if (gi < BLOCK_WORDS - 1) begin : g_mid
        assign win_next[gi] = shift_en ? win_reg[gi+1] : win_reg[gi];
      end else begin : g_top
        assign win_next[gi] = shift_en ? shift_in : win_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      lc_reg    <= 4'd0;
      t_reg     <= 6'd0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      lc_reg    <= lc_next;
      t_reg     <= t_next;
      win_reg   <= win_next;
    end
  end

  assign W     = win_reg[0];
  assign T     = t_reg;
  assign VALID = (state_reg == RUN);
  assign DONE  = (state_reg == FIN);

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: reset, "abc" schedule, full run, gaps,
// ignored inputs and adder overflow.
module tb_msg_schedule;

  logic        CLK;
  logic        RST;
  logic        LOAD;
  logic [31:0] DIN;
  logic        NEXT;
  logic [31:0] W;
  logic [5:0]  T;
  logic        VALID;
  logic        DONE;

  int n_tests;
  int n_fail;

  logic [31:0] blk   [16];
  logic [31:0] ref_w [64];

  msg_schedule dut (
    .CLK   (CLK),
    .RST   (RST),
    .LOAD  (LOAD),
    .DIN   (DIN),
    .NEXT  (NEXT),
    .W     (W),
    .T     (T),
    .VALID (VALID),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic compute_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) ref_w[t] = blk[t];
      else ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7] + ref_s0(ref_w[t-15]) + ref_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_ref();
  endtask

  // Drives 16 words with `gap` idle cycles between them; returns at the
  // negedge after the 16th capture, where VALID should first be high.
  task automatic load_block(input int gap, input bit chk_gap);
    for (int i = 0; i < 16; i++) begin
      LOAD = 1'b1;
      DIN  = blk[i];
      @(negedge CLK);
      LOAD = 1'b0;
      DIN  = 32'h0;
      if (i < 15) begin
        if (chk_gap) begin
          n_tests++;
          if (VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL load_valid_early word=%0d VALID=%b expected 0", i, VALID);
          end
        end
        for (int g = 0; g < gap; g++) begin
          @(negedge CLK);
          if (chk_gap) begin
            n_tests++;
            if (VALID !== 1'b0) begin
              n_fail++;
              $display("FAIL gap_valid_early word=%0d VALID=%b expected 0", i, VALID);
            end
          end
        end
      end
    end
  endtask

  task automatic drain();
    int k;
    NEXT = 1'b1;
    for (k = 0; k < 80 && DONE !== 1'b1; k++) @(negedge CLK);
    NEXT = 1'b0;
    n_tests++;
    if (DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done DONE=%b expected 1 within 80 cycles", DONE);
    end
    @(negedge CLK);
  endtask

  // Holds NEXT high from the first VALID cycle and checks all 64 rounds plus FIN.
  task automatic run_full(input bit junk_load, input bit hand);
    logic [31:0] hw;
    bit          has_hw;
    n_tests++;
    if (VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start VALID=%b expected 1", VALID);
    end
    NEXT = 1'b1;
    LOAD = junk_load;
    DIN  = junk_load ? 32'hDEADBEEF : 32'h0;
    for (int t = 0; t < 64; t++) begin
      n_tests++;
      if (VALID !== 1'b1 || T !== 6'(t) || W !== ref_w[t]) begin
        n_fail++;
        $display("FAIL run_word t=%0d VALID=%b T=%0d W=%h expected VALID=1 T=%0d W=%h",
                 t, VALID, T, W, t, ref_w[t]);
      end
      has_hw = 1'b1;
      case (t)
        0:  hw = 32'h61626380;
        15: hw = 32'h00000018;
        16: hw = 32'h61626380;
        17: hw = 32'h000F0000;
        18: hw = 32'h7DA86405;
        19: hw = 32'h600003C6;
        default: begin hw = 32'h0; has_hw = 1'b0; end
      endcase
      if (hand && has_hw) begin
        n_tests++;
        if (W !== hw) begin
          n_fail++;
          $display("FAIL abc_word t=%0d W=%h expected %h", t, W, hw);
        end
      end
      @(negedge CLK);
    end
    n_tests++;
    if (DONE !== 1'b1 || VALID !== 1'b0 || T === 6'd0) begin
      n_fail++;
      $display("FAIL fin_pulse DONE=%b VALID=%b T=%0d expected DONE=1 VALID=0 T!=0", DONE, VALID, T);
    end
    NEXT = 1'b0;
    @(negedge CLK);
    LOAD = 1'b0;
    DIN  = 32'h0;
    n_tests++;
    if (DONE !== 1'b0 || VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL after_fin DONE=%b VALID=%b expected 0 0", DONE, VALID);
    end
  endtask

  task automatic test_reset();
    RST  = 1'b0;
    LOAD = 1'b0;
    NEXT = 1'b0;
    DIN  = 32'h0;
    repeat (2) @(negedge CLK);
    n_tests++;
    if (VALID !== 1'b0 || DONE !== 1'b0 || T !== 6'd0 || W !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state VALID=%b DONE=%b T=%0d W=%h expected 0 0 0 0", VALID, DONE, T, W);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_abc_schedule();
    set_abc();
    load_block(0, 1'b1);
    run_full(1'b0, 1'b1);
  endtask

  task automatic test_ignored_load();
    set_abc();
    load_block(0, 1'b0);
    run_full(1'b1, 1'b1);
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 16; i++) blk[i] = (32'h01010101 * (i + 1)) ^ 32'hA5A5A5A5;
    compute_ref();
    load_block(2, 1'b1);
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (VALID !== 1'b1 || T !== 6'd0 || W !== blk[0]) begin
        n_fail++;
        $display("FAIL hold_t0 c=%0d VALID=%b T=%0d W=%h expected 1 0 %h", c, VALID, T, W, blk[0]);
      end
      @(negedge CLK);
    end
    NEXT = 1'b1;
    @(negedge CLK);
    NEXT = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (VALID !== 1'b1 || T !== 6'd1 || W !== blk[1]) begin
        n_fail++;
        $display("FAIL hold_t1 c=%0d VALID=%b T=%0d W=%h expected 1 1 %h", c, VALID, T, W, blk[1]);
      end
      @(negedge CLK);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    set_abc();
    load_block(0, 1'b0);
    NEXT = 1'b1;
    repeat (20) @(negedge CLK);
    NEXT = 1'b0;
    n_tests++;
    if (T !== 6'd20 || W !== ref_w[20]) begin
      n_fail++;
      $display("FAIL pre_reset T=%0d W=%h expected 20 %h", T, W, ref_w[20]);
    end
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (VALID !== 1'b0 || T !== 6'd0 || W !== 32'h0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset VALID=%b T=%0d W=%h DONE=%b expected 0 0 0 0", VALID, T, W, DONE);
    end
    @(negedge CLK);
    RST = 1'b1;
    // NEXT in IDLE must not move T, and must not disturb the load that follows.
    NEXT = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_tests++;
      if (T !== 6'd0 || VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_next c=%0d T=%0d VALID=%b expected 0 0", c, T, VALID);
      end
    end
    for (int i = 0; i < 16; i++) blk[i] = 32'h10000000 + 32'(i * 7);
    compute_ref();
    load_block(0, 1'b1);
    NEXT = 1'b0;
    n_tests++;
    if (VALID !== 1'b1 || T !== 6'd0 || W !== blk[0]) begin
      n_fail++;
      $display("FAIL reload VALID=%b T=%0d W=%h expected 1 0 %h", VALID, T, W, blk[0]);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    compute_ref();
    load_block(0, 1'b0);
    NEXT = 1'b1;
    repeat (16) @(negedge CLK);
    n_tests++;
    if (T !== 6'd16 || W !== 32'h203FFFFC) begin
      n_fail++;
      $display("FAIL overflow_hand T=%0d W=%h expected 16 203fffFC", T, W);
    end
    n_tests++;
    if (W !== ref_w[16] || (^W) === 1'bx) begin
      n_fail++;
      $display("FAIL overflow_model W=%h expected %h", W, ref_w[16]);
    end
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_abc_schedule();
    test_ignored_load();
    test_gapped();
    test_reset_mid_run();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
